uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver, the counterpart of the tracker's UART transmitter: 8N1 framing, LSB first, idle-high line.
- Runs on the 12 MHz system clock with an integer clocks-per-bit divider.
- Oversamples the asynchronous rx pin, samples each bit at its centre, and presents each received byte with a one-cycle strobe.
- Feeds command parsing from the host/companion MCU into the FPGA tracker.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); legal range >= 4.
- HALF, CLKS_PER_BIT/2 (integer divide), derived localparam, centre-sample offset; not overridable.

Ports:
- clk  in  1  system clock, 12 MHz.
- rstn  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- data  out  8  last correctly framed byte; bit 0 is the first data bit on the wire.
- rcv  out  1  one-cycle pulse: data was just updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state=IDLE; synchroniser flops=1; data=8'h00; rcv=0; frame_err=0; busy=0; counters=0.
  - Reset mid-frame aborts the frame with no strobe.
- Input sync: rx passes through 2 flops to give rx_s. Only rx_s is used internally.
- IDLE: on rx_s==0 -> START; baud counter cleared to 0.
- START:
  - Counter increments each cycle.
  - At count==HALF-1: if rx_s==1 it is a glitch -> IDLE, no strobe; else clear counter, bit index=0 -> DATA.
- DATA:
  - At count==CLKS_PER_BIT-1: shift rx_s into shift-register MSB (shift right), clear counter, increment bit index.
  - After the 8th sample -> STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: data<=shift register, rcv<=1 for exactly one cycle -> IDLE.
  - rx_s==0: frame_err<=1 for one cycle, data unchanged -> BREAK.
- BREAK: wait until rx_s==1 -> IDLE. Prevents a held-low line from re-triggering as a new start.
- Timing: if rx falls just before posedge E, IDLE leaves at edge E+2 (synchroniser latency).
  - Data bit i is sampled at edge E+2+HALF+(i+1)*CLKS_PER_BIT.
  - The stop bit is sampled at E+2+HALF+9*CLKS_PER_BIT.
  - rcv or frame_err is high in the cycle following that edge.
- Back-to-back frames: STOP returns to IDLE mid-stop-bit, so a start bit immediately following one stop bit is detected. No gap is required.
- rcv and frame_err are never high together.
- data is stable between rcv pulses. No overrun detection: the consumer must take data within one frame time.
- Counter width: clog2(CLKS_PER_BIT) bits. Bit index: 4 bits. The counter never wraps within a state.

Decomposition:
- Shared include (alongside the baud constants already used by the transmitter):
  - divider constants B115200=104, B57600=208, B9600=1250;
  - rx state encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3-bit).
- One sub-module, uart_rx_baudgen:
  - counter with clear input and two registered compare outputs, half_tick (count==HALF-1) and full_tick (count==CLKS_PER_BIT-1);
  - enabled only while busy.
- FSM, synchroniser and shift register stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=12, send 0xA5 with 1 stop bit after rx idle high -> data=0xA5; rcv high for 1 cycle at E+2+6+108 = E+116; frame_err stays 0.
- rx low for 4 cycles then high (glitch) -> state returns to IDLE at E+8; no rcv, no frame_err; data unchanged.
- Send 0x3C with stop bit forced 0, then hold low 40 cycles -> frame_err pulses once; data keeps the previous value; busy stays 1 until rx returns high, and no new start is detected during the low hold.
- Back-to-back 0x00 then 0xFF, each with exactly 1 stop bit -> two rcv pulses exactly 10*12=120 cycles apart; data=0x00 then 0xFF.
- Assert rstn=0 for one cycle midway through the data bits of 0x81 -> all outputs at reset values next cycle; the following clean frame 0x81 is received correctly.
- CLKS_PER_BIT=104, transmitter clock skewed +/-3% -> bytes 0x55, 0xAA and 0x00 are all received without frame_err.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and types shared by the UART receiver files.
//   B115200/B57600/B9600 : clocks-per-bit divider values for a 12 MHz clock
//   rx_state_t           : receiver FSM states (3-bit)
package uart_rx_pkg;

    localparam int unsigned B115200 = 104;
    localparam int unsigned B57600  = 208;
    localparam int unsigned B9600   = 1250;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte interface of the UART receiver.
//   data      : last correctly framed byte, bit 0 first on the wire
//   rcv       : one-cycle strobe, data just updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver is not idle
//   master    : receiver side (drives everything)
//   slave     : consumer side
interface uart_rx_if;

    logic [7:0] data;
    logic       rcv;
    logic       frame_err;
    logic       busy;

    modport master (output data, rcv, frame_err, busy);
    modport slave  (input  data, rcv, frame_err, busy);

endinterface

// File: rtl/uart_rx_baudgen.sv
// uart_rx_baudgen: bit-period counter for the UART receiver.
//   clk, rstn : clock, synchronous active-low reset
//   en        : count enable (receiver busy)
//   clr       : synchronous clear, wins over en
//   half_tick : high while count == CLKS_PER_BIT/2 - 1
//   full_tick : high while count == CLKS_PER_BIT - 1
module uart_rx_baudgen
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Ticks are compared against the next count so the registered flags
    // line up with the cycle in which cnt holds the compared value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            half_tick <= 1'b0;
            full_tick <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            half_tick <= (cnt_nxt == HALF_M1);
            full_tick <= (cnt_nxt == FULL_M1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line, centre sampling.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   rx   : asynchronous serial input
//   bus  : uart_rx_if.master (data, rcv, frame_err, busy)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = B115200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx,
    uart_rx_if.master   bus
);

    rx_state_t  state;
    rx_state_t  state_nxt;

    logic [1:0] sync;
    logic       rx_s;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic [3:0] bit_idx;
    logic       rcv_q;
    logic       ferr_q;

    logic       half_tick;
    logic       full_tick;
    logic       cnt_clr;
    logic       shift_en;
    logic       load_en;
    logic       err_en;
    logic       idx_clr;
    logic       busy;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];

    uart_rx_baudgen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baudgen (
        .clk       (clk),
        .rstn      (rstn),
        .en        (busy),
        .clr       (cnt_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_en   = 1'b0;
        err_en    = 1'b0;
        idx_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_tick) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_clr   = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 4'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        load_en   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_en    = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Counter held at zero so it cannot wrap during a long break.
                cnt_clr = 1'b1;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg   <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rcv_q  <= load_en;
            ferr_q <= err_en;
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 4'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
            if (load_en) begin
                data_q <= shreg;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.rcv       = rcv_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy;

endmodule
